// File: rtl/reg_file_rename_pkg.sv
// Shared widths and payload types for the renaming architectural register file.
package reg_file_rename_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned IDX_W = $clog2(NREG);

  // One operand read result: value, pending flag, producing ROB tag.
  typedef struct packed {
    logic [XLEN-1:0]  val;
    logic             busy;
    logic [TAG_W-1:0] tag;
  } rd_data_t;

  // ROB retirement payload.
  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] rd;
    logic [XLEN-1:0]  val;
    logic [TAG_W-1:0] tag;
  } commit_t;

  // x0 is hardwired to zero and never renamed.
  function automatic logic is_x0(input logic [IDX_W-1:0] idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/reg_file_rename_if.sv
// Decode/issue/commit bundle between the pipeline (master) and the register file (slave).
//  rdy, flush                          : global enable, mispredict flush
//  rs1_*/rs2_*                         : operand index in, value/busy/tag out
//  issue_en/issue_rd/issue_tag         : rename rd to a ROB slot
//  commit_en/commit_rd/commit_val/_tag : ROB retirement
interface reg_file_rename_if;
  import reg_file_rename_pkg::*;

  logic             rdy;
  logic             flush;
  logic [IDX_W-1:0] rs1_idx;
  logic [XLEN-1:0]  rs1_val;
  logic             rs1_busy;
  logic [TAG_W-1:0] rs1_tag;
  logic [IDX_W-1:0] rs2_idx;
  logic [XLEN-1:0]  rs2_val;
  logic             rs2_busy;
  logic [TAG_W-1:0] rs2_tag;
  logic             issue_en;
  logic [IDX_W-1:0] issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic             commit_en;
  logic [IDX_W-1:0] commit_rd;
  logic [XLEN-1:0]  commit_val;
  logic [TAG_W-1:0] commit_tag;

  modport master (
    output rdy, flush, rs1_idx, rs2_idx,
    output issue_en, issue_rd, issue_tag,
    output commit_en, commit_rd, commit_val, commit_tag,
    input  rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag
  );

  modport slave (
    input  rdy, flush, rs1_idx, rs2_idx,
    input  issue_en, issue_rd, issue_tag,
    input  commit_en, commit_rd, commit_val, commit_tag,
    output rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag
  );

endinterface

// File: rtl/reg_file_rename_read_port.sv
// Combinational operand read with commit forwarding.
//  idx    : register index
//  commit : retirement payload in flight this cycle
//  val_q/busy_q/tag_q : register file storage
//  rd     : value/busy/tag seen by decode
module reg_file_rename_read_port
  import reg_file_rename_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  commit_t          commit,
  input  logic [XLEN-1:0]  val_q  [NREG],
  input  logic             busy_q [NREG],
  input  logic [TAG_W-1:0] tag_q  [NREG],
  output rd_data_t         rd
);

  // Forward only when the retiring tag is the one this register waits on.
  always_comb begin
    rd.val  = val_q[idx];
    rd.busy = busy_q[idx];
    rd.tag  = tag_q[idx];
    if (is_x0(idx)) begin
      rd = '0;
    end else if (commit.en && (commit.rd == idx) && busy_q[idx] &&
                 (tag_q[idx] == commit.tag)) begin
      rd.val  = commit.val;
      rd.busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags; ROB commit sink.
//  clk : rising-edge clock
//  rst : asynchronous active-low reset
//  bus : reg_file_rename_if.slave (reads, issue, commit, flush, rdy)
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  reg_file_rename_if.slave     bus
);

  logic [XLEN-1:0]  val_q  [NREG];
  logic             busy_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];

  commit_t  commit;
  rd_data_t rd1;
  rd_data_t rd2;

  assign commit.en  = bus.commit_en;
  assign commit.rd  = bus.commit_rd;
  assign commit.val = bus.commit_val;
  assign commit.tag = bus.commit_tag;

  // Storage update: commit first, then flush/issue so issue wins on the same rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (bus.rdy) begin
      if (commit.en && !is_x0(commit.rd)) begin
        val_q[commit.rd] <= commit.val;
        if (busy_q[commit.rd] && (tag_q[commit.rd] == commit.tag)) begin
          busy_q[commit.rd] <= 1'b0;
        end
      end
      if (bus.flush) begin
        for (int unsigned i = 0; i < NREG; i++) begin
          busy_q[i] <= 1'b0;
        end
      end else if (bus.issue_en && !is_x0(bus.issue_rd)) begin
        busy_q[bus.issue_rd] <= 1'b1;
        tag_q[bus.issue_rd]  <= bus.issue_tag;
      end
    end
  end

  reg_file_rename_read_port u_rd1 (
    .idx    (bus.rs1_idx),
    .commit (commit),
    .val_q  (val_q),
    .busy_q (busy_q),
    .tag_q  (tag_q),
    .rd     (rd1)
  );

  reg_file_rename_read_port u_rd2 (
    .idx    (bus.rs2_idx),
    .commit (commit),
    .val_q  (val_q),
    .busy_q (busy_q),
    .tag_q  (tag_q),
    .rd     (rd2)
  );

  assign bus.rs1_val  = rd1.val;
  assign bus.rs1_busy = rd1.busy;
  assign bus.rs1_tag  = rd1.tag;
  assign bus.rs2_val  = rd2.val;
  assign bus.rs2_busy = rd2.busy;
  assign bus.rs2_tag  = rd2.tag;

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: vector table plus an async-reset sequence.
module tb_reg_file_rename;
  import reg_file_rename_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  reg_file_rename_if bus ();

  reg_file_rename dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rdy;
    logic             flush;
    logic             ie;
    logic [IDX_W-1:0] ird;
    logic [TAG_W-1:0] itag;
    logic             ce;
    logic [IDX_W-1:0] crd;
    logic [XLEN-1:0]  cval;
    logic [TAG_W-1:0] ctag;
    logic [IDX_W-1:0] r1;
    logic [IDX_W-1:0] r2;
    logic [XLEN-1:0]  e1v;
    logic             e1b;
    logic [TAG_W-1:0] e1t;
    logic [XLEN-1:0]  e2v;
    logic             e2b;
    logic [TAG_W-1:0] e2t;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rdy, input int flush, input int ie, input int ird,
                     input int itag, input int ce, input int crd, input int cval,
                     input int ctag, input int r1, input int r2,
                     input int e1v, input int e1b, input int e1t,
                     input int e2v, input int e2b, input int e2t);
    vec_t v;
    v.rdy  = 1'(rdy);   v.flush = 1'(flush);
    v.ie   = 1'(ie);    v.ird   = IDX_W'(ird);  v.itag = TAG_W'(itag);
    v.ce   = 1'(ce);    v.crd   = IDX_W'(crd);  v.cval = XLEN'(cval);
    v.ctag = TAG_W'(ctag);
    v.r1   = IDX_W'(r1); v.r2   = IDX_W'(r2);
    v.e1v  = XLEN'(e1v); v.e1b  = 1'(e1b);      v.e1t  = TAG_W'(e1t);
    v.e2v  = XLEN'(e2v); v.e2b  = 1'(e2b);      v.e2t  = TAG_W'(e2t);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ports(input string name, input logic [XLEN-1:0] e1v, input logic e1b,
                           input logic [TAG_W-1:0] e1t, input logic [XLEN-1:0] e2v,
                           input logic e2b, input logic [TAG_W-1:0] e2t);
    chk({name, " rs1_val"},  32'(bus.rs1_val),  32'(e1v));
    chk({name, " rs1_busy"}, 32'(bus.rs1_busy), 32'(e1b));
    chk({name, " rs1_tag"},  32'(bus.rs1_tag),  32'(e1t));
    chk({name, " rs2_val"},  32'(bus.rs2_val),  32'(e2v));
    chk({name, " rs2_busy"}, 32'(bus.rs2_busy), 32'(e2b));
    chk({name, " rs2_tag"},  32'(bus.rs2_tag),  32'(e2t));
  endtask

  task automatic drive(input vec_t v);
    bus.rdy        = v.rdy;
    bus.flush      = v.flush;
    bus.issue_en   = v.ie;
    bus.issue_rd   = v.ird;
    bus.issue_tag  = v.itag;
    bus.commit_en  = v.ce;
    bus.commit_rd  = v.crd;
    bus.commit_val = v.cval;
    bus.commit_tag = v.ctag;
    bus.rs1_idx    = v.r1;
    bus.rs2_idx    = v.r2;
  endtask

  task automatic idle(input int r1, input int r2);
    bus.rdy = 1'b1; bus.flush = 1'b0; bus.issue_en = 1'b0; bus.commit_en = 1'b0;
    bus.issue_rd = '0; bus.issue_tag = '0; bus.commit_rd = '0;
    bus.commit_val = '0; bus.commit_tag = '0;
    bus.rs1_idx = IDX_W'(r1); bus.rs2_idx = IDX_W'(r2);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    idle(5, 31);
    #2;
    chk_ports("reset", '0, 1'b0, '0, '0, 1'b0, '0);
    #1 rst = 1'b1;

    // rdy flush | ie ird itag | ce crd cval ctag | r1 r2 | e1 v b t | e2 v b t
    add(1,0, 0,0,0,  0,0,0,0,        3,0, 0,0,0,      0,0,0);   // 0 x3 clean
    add(1,0, 1,3,2,  0,0,0,0,        3,0, 0,0,0,      0,0,0);   // 1 issue hidden same cycle
    add(1,0, 0,0,0,  0,0,0,0,        3,0, 0,1,2,      0,0,0);   // 2 x3 busy tag 2
    add(1,0, 0,0,0,  1,3,'hAA,2,     3,3, 'hAA,0,2,   'hAA,0,2); // 3 forward on both ports
    add(1,0, 0,0,0,  0,0,0,0,        3,0, 'hAA,0,2,   0,0,0);   // 4 stored
    add(1,0, 1,4,1,  0,0,0,0,        4,3, 0,0,0,      'hAA,0,2); // 5
    add(1,0, 1,4,5,  0,0,0,0,        4,0, 0,1,1,      0,0,0);   // 6 rename again
    add(1,0, 0,0,0,  1,4,7,1,        4,0, 0,1,5,      0,0,0);   // 7 stale tag: no forward
    add(1,0, 0,0,0,  0,0,0,0,        4,0, 7,1,5,      0,0,0);   // 8 value written, still busy
    add(1,0, 1,6,3,  1,6,9,0,        6,0, 0,0,0,      0,0,0);   // 9 issue+commit same rd
    add(1,0, 0,0,0,  0,0,0,0,        6,0, 9,1,3,      0,0,0);   // 10 issue wins
    add(1,0, 1,0,7,  1,0,'hFFFF,0,   0,0, 0,0,0,      0,0,0);   // 11 x0 writes
    add(1,0, 0,0,0,  0,0,0,0,        0,0, 0,0,0,      0,0,0);   // 12 x0 still zero
    add(1,0, 1,1,8,  0,0,0,0,        1,0, 0,0,0,      0,0,0);   // 13
    add(1,0, 1,2,9,  0,0,0,0,        1,2, 0,1,8,      0,0,0);   // 14
    add(1,1, 1,7,10, 1,1,'h55,8,     1,2, 'h55,0,8,   0,1,9);   // 15 flush+issue+commit
    add(1,0, 0,0,0,  0,0,0,0,        2,7, 0,0,9,      0,0,0);   // 16 flushed, x7 ignored
    add(0,0, 1,2,11, 1,1,'h66,8,     1,2, 'h55,0,8,   0,0,9);   // 17 rdy low
    add(1,0, 0,0,0,  0,0,0,0,        1,2, 'h55,0,8,   0,0,9);   // 18 frozen
    add(1,0, 0,0,0,  0,0,0,0,        4,3, 7,0,5,      'hAA,0,2); // 19
    add(1,0, 0,0,0,  0,0,0,0,        6,0, 9,0,3,      0,0,0);   // 20

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk_ports($sformatf("vec%0d", i), vecs[i].e1v, vecs[i].e1b, vecs[i].e1t,
                vecs[i].e2v, vecs[i].e2b, vecs[i].e2t);
      @(posedge clk); #1;
    end

    // Mid-run asynchronous reset with x5 busy holding 0x1234.
    idle(0, 0);
    bus.commit_en = 1'b1; bus.commit_rd = 5; bus.commit_val = 32'h1234;
    @(posedge clk); #1;
    idle(0, 0);
    bus.issue_en = 1'b1; bus.issue_rd = 5; bus.issue_tag = 4;
    @(posedge clk); #1;
    idle(5, 3);
    @(negedge clk);
    chk_ports("pre_rst", 32'h1234, 1'b1, 4'd4, 32'hAA, 1'b0, 4'd2);
    #1 rst = 1'b0;
    #1;
    chk_ports("async_rst", '0, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    idle(5, 6);
    @(posedge clk); #1;
    chk_ports("post_rst", '0, 1'b0, '0, '0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
